spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 187 ++++++++++++++++++
 tb/tb_spi_master.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI mode-0 master: one byte per start, MSB first; chip select can be held
// open between bytes (WAIT) so several bytes form a single frame.
module spi_master #(
  parameter int HALF_PERIOD = 8,
  parameter int CS_SETUP    = 8,
  parameter int CS_HOLD     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       last,
  input  logic       cs_release,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       spi_scs,
  output logic       spi_sck,
  output logic       spi_sdo,
  input  logic       spi_sdi
);

  localparam int MAX_A   = (HALF_PERIOD > CS_SETUP) ? HALF_PERIOD : CS_SETUP;
  localparam int MAX_CNT = (MAX_A > CS_HOLD) ? MAX_A : CS_HOLD;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] HP_END    = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] SETUP_END = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_END  = CW'(CS_HOLD - 1);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, WAIT} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      bit_reg, bit_next;
  logic [7:0]      tx_reg, tx_next;
  logic [7:0]      rx_shift_reg, rx_shift_next;
  logic [7:0]      rx_data_reg, rx_data_next;
  logic            last_reg, last_next;
  logic            hold_done_reg, hold_done_next;
  logic            done_reg, done_next;
  logic            scs_reg, sck_reg, busy_reg;
  logic            sdi_meta_reg, sdi_sync_reg;

  // Two-flop synchroniser for the asynchronous MISO line; no reset needed.
  always_ff @(posedge clk) begin
    sdi_meta_reg <= spi_sdi;
    sdi_sync_reg <= sdi_meta_reg;
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_next       = bit_reg;
    tx_next        = tx_reg;
    rx_shift_next  = rx_shift_reg;
    rx_data_next   = rx_data_reg;
    last_next      = last_reg;
    hold_done_next = hold_done_reg;
    done_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          tx_next    = tx_data;
          last_next  = last;
          cnt_next   = '0;
          bit_next   = '0;
          state_next = SETUP;
        end
      end

      SETUP: begin
        if (cnt_reg == SETUP_END) begin
          cnt_next   = '0;
          state_next = LOW;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      LOW: begin
        if (cnt_reg == HP_END) begin
          cnt_next   = '0;
          state_next = HIGH;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      HIGH: begin
        if (cnt_reg == HP_END) begin
          cnt_next      = '0;
          rx_shift_next = {rx_shift_reg[6:0], sdi_sync_reg};
          // The 3-bit counter wraps back to 0 after bit 0 has been sent.
          bit_next      = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
            if (last_reg) begin
              hold_done_next = 1'b1;
              state_next     = HOLD;
            end else begin
              done_next    = 1'b1;
              rx_data_next = rx_shift_next;
              state_next   = WAIT;
            end
          end else begin
            tx_next    = {tx_reg[6:0], 1'b0};
            state_next = LOW;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      HOLD: begin
        if (cnt_reg == HOLD_END) begin
          cnt_next   = '0;
          state_next = IDLE;
          if (hold_done_reg) begin
            done_next    = 1'b1;
            rx_data_next = rx_shift_reg;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      WAIT: begin
        if (start) begin
          tx_next    = tx_data;
          last_next  = last;
          cnt_next   = '0;
          bit_next   = '0;
          state_next = LOW;
        end else if (cs_release) begin
          hold_done_next = 1'b0;
          cnt_next       = '0;
          state_next     = HOLD;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Pin-level outputs are registered from the next state so they change
  // cleanly on the same edge the state does.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_reg       <= '0;
      tx_reg        <= '0;
      rx_shift_reg  <= '0;
      rx_data_reg   <= '0;
      last_reg      <= 1'b0;
      hold_done_reg <= 1'b0;
      done_reg      <= 1'b0;
      scs_reg       <= 1'b1;
      sck_reg       <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_reg       <= bit_next;
      tx_reg        <= tx_next;
      rx_shift_reg  <= rx_shift_next;
      rx_data_reg   <= rx_data_next;
      last_reg      <= last_next;
      hold_done_reg <= hold_done_next;
      done_reg      <= done_next;
      scs_reg       <= (state_next == IDLE);
      sck_reg       <= (state_next == HIGH);
      busy_reg      <= (state_next inside {SETUP, LOW, HIGH, HOLD});
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign rx_data = rx_data_reg;
  assign spi_scs = scs_reg;
  assign spi_sck = sck_reg;
  assign spi_sdo = tx_reg[7];

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: three parameter sets, directed frames
// followed by random frames, against loopback or a mode-0 slave model.
module tb_spi_master;

  localparam int NI = 3;
  localparam int HP_T [NI] = '{8, 2, 3};
  localparam int SU_T [NI] = '{8, 1, 2};
  localparam int HO_T [NI] = '{8, 1, 5};

  typedef struct {
    int          inst;
    logic [7:0]  rx;
    logic [7:0]  tx;
    int unsigned lat;
    int unsigned start_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NI-1:0] rst_s, start_s, last_s, rel_s, loop_s;
  logic [7:0]    tx_s [NI];
  logic [7:0]    slave_byte [NI];
  wire  [NI-1:0] busy_w, done_w, scs_w, sck_w, sdo_w, sdi_w;
  wire  [7:0]    rx_w [NI];

  // Observation state maintained by the monitor process only.
  int unsigned rise_cnt [NI];
  int unsigned rise_base [NI];
  int unsigned scs_rise_cnt [NI];
  logic [7:0]  cap_tx [NI];
  logic [2:0]  slv_bit [NI];
  logic [NI-1:0] sck_prev = '0;
  logic [NI-1:0] scs_prev = '1;

  exp_t sb_q [$];
  int   n_total = 0;
  int   n_pass  = 0;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    spi_master #(
      .HALF_PERIOD(HP_T[gi]),
      .CS_SETUP   (SU_T[gi]),
      .CS_HOLD    (HO_T[gi])
    ) dut (
      .clk       (clk),
      .rst       (rst_s[gi]),
      .start     (start_s[gi]),
      .last      (last_s[gi]),
      .cs_release(rel_s[gi]),
      .tx_data   (tx_s[gi]),
      .busy      (busy_w[gi]),
      .done      (done_w[gi]),
      .rx_data   (rx_w[gi]),
      .spi_scs   (scs_w[gi]),
      .spi_sck   (sck_w[gi]),
      .spi_sdo   (sdo_w[gi]),
      .spi_sdi   (sdi_w[gi])
    );
    // Slave presents MSB first from chip-select fall, advancing on each sck fall.
    assign sdi_w[gi] = loop_s[gi] ? sdo_w[gi] : slave_byte[gi][~slv_bit[gi]];
  end

  function void check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s inst%0d: got %0h expected %0h", name, k, act, exp_v);
  endfunction

  // Monitor: edge bookkeeping, slave model and scoreboard checks at each done.
  initial begin
    for (int k = 0; k < NI; k++) begin
      rise_cnt[k] = 0; rise_base[k] = 0; scs_rise_cnt[k] = 0;
      cap_tx[k] = 8'h00; slv_bit[k] = 3'd0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (sck_w[k] === 1'b1 && sck_prev[k] === 1'b0) begin
          rise_cnt[k]++;
          cap_tx[k] = {cap_tx[k][6:0], sdo_w[k]};
        end
        if (sck_w[k] === 1'b0 && sck_prev[k] === 1'b1) slv_bit[k] = slv_bit[k] + 3'd1;
        if (scs_w[k] === 1'b1 && scs_prev[k] === 1'b0) begin
          scs_rise_cnt[k]++;
          slv_bit[k] = 3'd0;
        end
        sck_prev[k] = sck_w[k];
        scs_prev[k] = scs_w[k];
        if (rst_s[k]) begin
          rise_base[k] = rise_cnt[k];
        end else if (done_w[k] === 1'b1) begin
          if (sb_q.size() == 0 || sb_q[0].inst != k) begin
            check("unexpected_done", k, 32'(done_w[k]), 32'd0);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("rx_data", k, 32'(rx_w[k]), 32'(e.rx));
            check("sdo_bits", k, 32'(cap_tx[k]), 32'(e.tx));
            check("sck_pulses", k, rise_cnt[k] - rise_base[k], 32'd8);
            check("latency", k, cyc - e.start_cyc, e.lat);
            $display("byte inst%0d tx=%02h rx=%02h cycles=%0d", k, cap_tx[k], rx_w[k], cyc - e.start_cyc);
          end
          rise_base[k] = rise_cnt[k];
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Start-to-done latency, counted in clk edges from the edge that accepts
  // start to the edge that raises done, is exactly:
  //   (from IDLE ? CS_SETUP : 0) + 16*HALF_PERIOD + (last ? CS_HOLD : 0)
  // so a single byte with last=1 takes CS_SETUP + 16*HALF_PERIOD + CS_HOLD.
  task automatic issue(input int k, input logic [7:0] tx, input logic lst,
                       input logic from_wait, input logic [7:0] slv, input logic rel);
    exp_t e;
    slave_byte[k] = slv;
    tx_s[k]       = tx;
    last_s[k]     = lst;
    rel_s[k]      = rel;
    start_s[k]    = 1'b1;
    @(negedge clk);
    start_s[k]  = 1'b0;
    rel_s[k]    = 1'b0;
    e.inst      = k;
    e.tx        = tx;
    e.rx        = loop_s[k] ? tx : slv;
    e.lat       = 16 * HP_T[k] + (from_wait ? 0 : SU_T[k]) + (lst ? HO_T[k] : 0);
    e.start_cyc = cyc;
    sb_q.push_back(e);
    check("busy_after_start", k, 32'(busy_w[k]), 32'd1);
  endtask

  task automatic wait_done(input int k);
    int t = 0;
    int budget = SU_T[k] + 16 * HP_T[k] + HO_T[k] + 8;
    while (done_w[k] !== 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("done_within_budget", k, 32'(done_w[k]), 32'd1);
  endtask

  task automatic run_directed(input int k);
    int unsigned r0, s0;
    int t;
    // Single byte, loopback.
    loop_s[k] = 1'b1;
    issue(k, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0);
    wait_done(k);
    check("scs_after_hold", k, 32'(scs_w[k]), 32'd1);
    check("idle_busy", k, 32'(busy_w[k]), 32'd0);
    // Two-byte burst with chip select held low throughout.
    tick(1);
    s0 = scs_rise_cnt[k];
    issue(k, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0);
    wait_done(k);
    check("wait_busy", k, 32'(busy_w[k]), 32'd0);
    check("wait_scs", k, 32'(scs_w[k]), 32'd0);
    issue(k, 8'h34, 1'b1, 1'b1, 8'h00, 1'b0);
    wait_done(k);
    tick(1);
    check("burst_scs_rises", k, scs_rise_cnt[k] - s0, 32'd1);
    // Slave returning 0x3C.
    loop_s[k] = 1'b0;
    issue(k, 8'($urandom), 1'b1, 1'b0, 8'h3C, 1'b0);
    wait_done(k);
    check("rx_slave_3c", k, 32'(rx_w[k]), 32'h3C);
    // Frame closed by cs_release; a start during HOLD must be dropped.
    issue(k, 8'($urandom), 1'b0, 1'b0, 8'($urandom), 1'b0);
    wait_done(k);
    rel_s[k] = 1'b1;
    @(negedge clk);
    rel_s[k] = 1'b0;
    check("release_hold_busy", k, 32'(busy_w[k]), 32'd1);
    check("release_hold_scs", k, 32'(scs_w[k]), 32'd0);
    tx_s[k]    = 8'hFF;
    start_s[k] = 1'b1;
    @(negedge clk);
    start_s[k] = 1'b0;
    r0 = rise_cnt[k];
    if (HO_T[k] > 1) begin
      repeat (HO_T[k] - 2) @(negedge clk);
      check("release_busy_before_end", k, 32'(busy_w[k]), 32'd1);
      @(negedge clk);
    end
    check("release_scs_high", k, 32'(scs_w[k]), 32'd1);
    check("release_busy_low", k, 32'(busy_w[k]), 32'd0);
    tick(SU_T[k] + HP_T[k] + 4);
    check("dropped_start_sck", k, rise_cnt[k] - r0, 32'd0);
    check("dropped_start_busy", k, 32'(busy_w[k]), 32'd0);
    // start and cs_release together in WAIT: start wins.
    issue(k, 8'($urandom), 1'b0, 1'b0, 8'($urandom), 1'b0);
    wait_done(k);
    s0 = scs_rise_cnt[k];
    issue(k, 8'($urandom), 1'b1, 1'b1, 8'($urandom), 1'b1);
    wait_done(k);
    tick(1);
    check("start_wins_scs_rises", k, scs_rise_cnt[k] - s0, 32'd1);
    // Reset after the 4th sck rise aborts the byte.
    loop_s[k]  = 1'b1;
    r0         = rise_cnt[k];
    tx_s[k]    = 8'($urandom);
    last_s[k]  = 1'b1;
    start_s[k] = 1'b1;
    @(negedge clk);
    start_s[k] = 1'b0;
    t = 0;
    while (rise_cnt[k] - r0 < 4 && t < SU_T[k] + 8 * HP_T[k] + 10) begin
      @(negedge clk);
      t++;
    end
    check("abort_4th_rise", k, rise_cnt[k] - r0, 32'd4);
    rst_s[k] = 1'b1;
    @(negedge clk);
    rst_s[k] = 1'b0;
    check("abort_scs", k, 32'(scs_w[k]), 32'd1);
    check("abort_sck", k, 32'(sck_w[k]), 32'd0);
    check("abort_rx", k, 32'(rx_w[k]), 32'h00);
    check("abort_busy", k, 32'(busy_w[k]), 32'd0);
    check("abort_done", k, 32'(done_w[k]), 32'd0);
    tick(2);
    issue(k, 8'($urandom), 1'b1, 1'b0, 8'h00, 1'b0);
    wait_done(k);
  endtask

  task automatic run_random(input int k, input int nf);
    int nb;
    bit by_rel;
    for (int f = 0; f < nf; f++) begin
      nb     = $urandom_range(1, 3);
      by_rel = ($urandom_range(0, 2) == 0);
      loop_s[k] = 1'($urandom);
      for (int b = 0; b < nb; b++) begin
        issue(k, 8'($urandom), (b == nb - 1) && !by_rel, b > 0, 8'($urandom), 1'b0);
        if ($urandom_range(0, 1) == 1) begin
          tick(2);
          rel_s[k] = 1'b1;
          @(negedge clk);
          rel_s[k] = 1'b0;
        end
        wait_done(k);
      end
      if (by_rel) begin
        rel_s[k] = 1'b1;
        @(negedge clk);
        rel_s[k] = 1'b0;
        tick(HO_T[k]);
      end
      check("frame_end_scs", k, 32'(scs_w[k]), 32'd1);
      check("frame_end_busy", k, 32'(busy_w[k]), 32'd0);
      tick($urandom_range(0, 3));
    end
  endtask

  initial begin
    rst_s   = '1;
    start_s = '0;
    last_s  = '0;
    rel_s   = '0;
    loop_s  = '1;
    for (int k = 0; k < NI; k++) begin
      tx_s[k]       = 8'h00;
      slave_byte[k] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("reset_scs", k, 32'(scs_w[k]), 32'd1);
      check("reset_sck", k, 32'(sck_w[k]), 32'd0);
      check("reset_sdo", k, 32'(sdo_w[k]), 32'd0);
      check("reset_busy", k, 32'(busy_w[k]), 32'd0);
      check("reset_done", k, 32'(done_w[k]), 32'd0);
      check("reset_rx", k, 32'(rx_w[k]), 32'h00);
    end
    rst_s = '0;
    tick(2);
    for (int k = 0; k < NI; k++) begin
      run_directed(k);
      run_random(k, 6);
    end
    tick(4);
    check("scoreboard_empty", 0, 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
